dot_product_sequencer: RTL and testbench

//  Upstream control stage for the matrix accelerator. Accepts a stream of operand pairs (a,b) ending in a

---
 rtl/dot_product_sequencer.sv | 176 +++++++++++++++++
 tb/tb_dot_product_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_sequencer.sv
// Control stage for the matrix accelerator: packs operand pairs P at a time into the multiplier lanes,
// steps the accelerator through multiply, accumulate and final reduction, and returns the dot product.
module dot_product_sequencer #(
    parameter int unsigned P        = 4,
    parameter int unsigned BW       = 16,
    parameter int unsigned AW       = 2,
    parameter int unsigned XBAR_LAT = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [BW-1:0]     op_a,
    input  logic [BW-1:0]     op_b,
    input  logic              op_last,
    output logic [P*BW-1:0]   mul_a_o,
    output logic [P*BW-1:0]   mul_b_o,
    output logic [P-1:0]      m_start_o,
    input  logic [P-1:0]      m_ready_i,
    output logic              direct_o,
    output logic [AW-1:0]     addr_sel_o,
    output logic [P-1:0]      add_o,
    output logic              final_add_o,
    input  logic              final_ready_i,
    input  logic [2*BW-1:0]   final_acc_i,
    output logic              acc_clr_o,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [2*BW-1:0]   res_data
);

    localparam int unsigned IW = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned CW = (XBAR_LAT > 1) ? $clog2(XBAR_LAT) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(P - 1);
    localparam logic [CW-1:0] XLAST    = CW'(XBAR_LAT - 1);

    typedef enum logic [3:0] {
        S_FILL,
        S_ISSUE,
        S_WAIT_MUL,
        S_XWAIT,
        S_ADD,
        S_FINAL,
        S_WAIT_FIN,
        S_OUT,
        S_CLEAR
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic            last_q;
    logic            mul_first;
    logic [CW-1:0]   xcnt;

    // The crossbar is only ever used in direct mode at address 0.
    assign direct_o   = 1'b1;
    assign addr_sel_o = '0;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= S_FILL;
            idx         <= '0;
            last_q      <= 1'b0;
            mul_first   <= 1'b0;
            xcnt        <= '0;
            op_ready    <= 1'b0;
            mul_a_o     <= '0;
            mul_b_o     <= '0;
            m_start_o   <= '0;
            add_o       <= '0;
            final_add_o <= 1'b0;
            acc_clr_o   <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
        end else begin
            case (state)
                S_FILL: begin
                    if (op_valid && op_ready) begin
                        for (int k = 0; k < P; k++) begin
                            if (idx == IW'(k)) begin
                                mul_a_o[k*BW +: BW] <= op_a;
                                mul_b_o[k*BW +: BW] <= op_b;
                            end
                        end
                        idx    <= idx + IW'(1);
                        last_q <= op_last;
                        // Batch closes on a full set of lanes or on the vector's last pair.
                        if (op_last || idx == LAST_IDX) begin
                            state     <= S_ISSUE;
                            op_ready  <= 1'b0;
                            m_start_o <= '1;
                        end
                    end else begin
                        op_ready <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    m_start_o <= '0;
                    mul_first <= 1'b1;
                    state     <= S_WAIT_MUL;
                end
                S_WAIT_MUL: begin
                    // m_ready_i may still show the previous batch during the first cycle.
                    if (mul_first) begin
                        mul_first <= 1'b0;
                    end else if (&m_ready_i) begin
                        if (XBAR_LAT == 0) begin
                            state <= S_ADD;
                            add_o <= '1;
                        end else begin
                            state <= S_XWAIT;
                            xcnt  <= '0;
                        end
                    end
                end
                S_XWAIT: begin
                    if (xcnt == XLAST) begin
                        state <= S_ADD;
                        add_o <= '1;
                    end else begin
                        xcnt <= xcnt + CW'(1);
                    end
                end
                S_ADD: begin
                    add_o   <= '0;
                    mul_a_o <= '0;
                    mul_b_o <= '0;
                    idx     <= '0;
                    if (last_q) begin
                        state       <= S_FINAL;
                        final_add_o <= 1'b1;
                    end else begin
                        state    <= S_FILL;
                        op_ready <= 1'b1;
                    end
                end
                S_FINAL: begin
                    final_add_o <= 1'b0;
                    state       <= S_WAIT_FIN;
                end
                S_WAIT_FIN: begin
                    if (final_ready_i) begin
                        res_data  <= final_acc_i;
                        res_valid <= 1'b1;
                        state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        acc_clr_o <= 1'b1;
                        state     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    acc_clr_o <= 1'b0;
                    last_q    <= 1'b0;
                    op_ready  <= 1'b1;
                    state     <= S_FILL;
                end
                default: begin
                    state       <= S_FILL;
                    idx         <= '0;
                    last_q      <= 1'b0;
                    op_ready    <= 1'b0;
                    m_start_o   <= '0;
                    add_o       <= '0;
                    final_add_o <= 1'b0;
                    acc_clr_o   <= 1'b0;
                    res_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Randomized bench for dot_product_sequencer: a behavioural accelerator drives the handshakes and
// every job's result and lane packing are compared with values computed directly from the vectors.
module tb_dot_product_sequencer;

    localparam int unsigned P  = 4;
    localparam int unsigned BW = 16;
    localparam int unsigned AW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              op_valid;
    logic              op_ready;
    logic [BW-1:0]     op_a;
    logic [BW-1:0]     op_b;
    logic              op_last;
    logic [P*BW-1:0]   mul_a_o;
    logic [P*BW-1:0]   mul_b_o;
    logic [P-1:0]      m_start_o;
    logic [P-1:0]      m_ready;
    logic              direct_o;
    logic [AW-1:0]     addr_sel_o;
    logic [P-1:0]      add_o;
    logic              final_add_o;
    logic              final_ready;
    logic [2*BW-1:0]   final_acc;
    logic              acc_clr_o;
    logic              res_valid;
    logic              res_ready;
    logic [2*BW-1:0]   res_data;

    always #5 clk = ~clk;

    dot_product_sequencer #(.P(P), .BW(BW), .AW(AW), .XBAR_LAT(1)) dut (
        .Clk          (clk),
        .Rst          (rst),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_last      (op_last),
        .mul_a_o      (mul_a_o),
        .mul_b_o      (mul_b_o),
        .m_start_o    (m_start_o),
        .m_ready_i    (m_ready),
        .direct_o     (direct_o),
        .addr_sel_o   (addr_sel_o),
        .add_o        (add_o),
        .final_add_o  (final_add_o),
        .final_ready_i(final_ready),
        .final_acc_i  (final_acc),
        .acc_clr_o    (acc_clr_o),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Behavioural accelerator: per-lane multipliers with random latency, lane accumulators, reduction.
    int          max_skew = 0;
    int          max_fin  = 0;
    logic [31:0] prod [P];
    logic [31:0] acc  [P];
    int          dly  [P];
    int          fdly;
    logic        fpend;

    function automatic logic [31:0] sum_acc();
        logic [31:0] s = 32'd0;
        for (int k = 0; k < P; k++) s = s + acc[k];
        return s;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < P; k++) begin
                prod[k]    <= 32'd0;
                acc[k]     <= 32'd0;
                dly[k]     <= 0;
                m_ready[k] <= 1'b1;
            end
            final_ready <= 1'b0;
            final_acc   <= 32'd0;
            fpend       <= 1'b0;
            fdly        <= 0;
        end else begin
            for (int k = 0; k < P; k++) begin
                if (m_start_o[k]) begin
                    prod[k]    <= 32'(mul_a_o[k*BW +: BW]) * 32'(mul_b_o[k*BW +: BW]);
                    m_ready[k] <= 1'b0;
                    dly[k]     <= int'($urandom_range(max_skew, 0));
                end else if (!m_ready[k]) begin
                    if (dly[k] == 0) m_ready[k] <= 1'b1;
                    else dly[k] <= dly[k] - 1;
                end
                if (acc_clr_o) acc[k] <= 32'd0;
                else if (add_o[k]) acc[k] <= acc[k] + prod[k];
            end
            if (final_add_o) begin
                final_ready <= 1'b0;
                fpend       <= 1'b1;
                fdly        <= int'($urandom_range(max_fin, 0));
            end else if (fpend) begin
                if (fdly == 0) begin
                    final_ready <= 1'b1;
                    final_acc   <= sum_acc();
                    fpend       <= 1'b0;
                end else begin
                    fdly <= fdly - 1;
                end
            end
            if (acc_clr_o) final_ready <= 1'b0;
        end
    end

    // Pulse monitor: counts pulses, snapshots lanes at each start, flags protocol violations.
    int          n_start = 0;
    int          n_add   = 0;
    int          n_final = 0;
    int          n_clr   = 0;
    int          n_viol  = 0;
    logic [63:0] snap_a [64];
    logic [63:0] snap_b [64];
    logic [3:0]  prev_p = 4'b0;
    logic [3:0]  cur_p;
    logic        viol_now;

    assign cur_p    = {|m_start_o, |add_o, final_add_o, acc_clr_o};
    assign viol_now = (|(cur_p & prev_p))
                   || (m_start_o != '0 && m_start_o != '1)
                   || (add_o != '0 && (add_o != '1 || m_ready != '1))
                   || (op_ready && res_valid);

    always @(posedge clk) begin
        prev_p <= cur_p;
        if (viol_now) n_viol <= n_viol + 1;
        if (m_start_o != '0) begin
            snap_a[n_start % 64] <= mul_a_o;
            snap_b[n_start % 64] <= mul_b_o;
            n_start <= n_start + 1;
        end
        if (add_o != '0) n_add <= n_add + 1;
        if (final_add_o) n_final <= n_final + 1;
        if (acc_clr_o) n_clr <= n_clr + 1;
    end

    logic [15:0] va [16];
    logic [15:0] vb [16];

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input logic last);
        int n = 0;
        op_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        op_last  = last;
        while (!op_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("op_ready_timeout", 64'(op_ready), 64'd1);
        @(negedge clk);
        op_valid = 1'b0;
        op_last  = 1'b0;
    endtask

    task automatic run_job(input int n, input int gap_max, input int hold);
        int          s0 = n_start;
        int          a0 = n_add;
        int          f0 = n_final;
        int          c0 = n_clr;
        int          nb = (n + int'(P) - 1) / int'(P);
        int          t  = 0;
        int          li;
        logic [31:0] exp = 32'd0;
        logic [63:0] ea;
        logic [63:0] eb;
        for (int i = 0; i < n; i++) exp = exp + 32'(va[i]) * 32'(vb[i]);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gap_max, 0)) @(negedge clk);
            send_pair(va[i], vb[i], i == n - 1);
        end
        while (!res_valid && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("res_valid", 64'(res_valid), 64'd1);
        check("res_data", 64'(res_data), 64'(exp));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 64'(res_valid), 64'd1);
            check("hold_data", 64'(res_data), 64'(exp));
            check("hold_op_ready", 64'(op_ready), 64'd0);
        end
        check("clr_before_hs", 64'(n_clr - c0), 64'd0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("acc_clr_after_hs", 64'(acc_clr_o), 64'd1);
        check("res_valid_drop", 64'(res_valid), 64'd0);
        @(negedge clk);
        check("clr_count", 64'(n_clr - c0), 64'd1);
        check("acc_clr_width", 64'(acc_clr_o), 64'd0);
        check("start_count", 64'(n_start - s0), 64'(nb));
        check("add_count", 64'(n_add - a0), 64'(nb));
        check("final_count", 64'(n_final - f0), 64'd1);
        check("violations", 64'(n_viol), 64'd0);
        for (int j = 0; j < nb; j++) begin
            ea = 64'd0;
            eb = 64'd0;
            for (int k = 0; k < int'(P); k++) begin
                li = j * int'(P) + k;
                if (li < n) begin
                    ea[k*16 +: 16] = va[li];
                    eb[k*16 +: 16] = vb[li];
                end
            end
            check("lanes_a", snap_a[(s0 + j) % 64], ea);
            check("lanes_b", snap_b[(s0 + j) % 64], eb);
        end
    endtask

    initial begin
        int t;
        rst       = 1'b1;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_last   = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_op_ready", 64'(op_ready), 64'd0);
        check("rst_pulses", 64'({m_start_o, add_o, final_add_o, acc_clr_o}), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_mul", 64'({mul_a_o, mul_b_o}), 64'd0);
        check("rst_xbar", 64'({direct_o, addr_sel_o}), 64'b100);
        rst = 1'b0;
        @(negedge clk);

        // Single full batch.
        for (int i = 0; i < 4; i++) begin
            va[i] = 16'(i + 1);
            vb[i] = 16'(i + 5);
        end
        run_job(4, 0, 0);
        check("t1_literal", 64'(res_data), 64'd70);

        // Two batches, second partially filled.
        for (int i = 0; i < 6; i++) begin
            va[i] = 16'(i + 1);
            vb[i] = 16'd2;
        end
        run_job(6, 0, 0);
        check("t2_literal", 64'(res_data), 64'd42);

        // Single pair at full scale.
        va[0] = 16'hFFFF;
        vb[0] = 16'hFFFF;
        run_job(1, 0, 0);
        check("t3_literal", 64'(res_data), 64'hFFFE0001);

        // Backpressure on the result port.
        for (int i = 0; i < 3; i++) begin
            va[i] = 16'($urandom);
            vb[i] = 16'($urandom);
        end
        run_job(3, 0, 10);

        // Reset while waiting on the multipliers.
        max_skew = 8;
        for (int i = 0; i < 4; i++) send_pair(16'(i + 9), 16'(i + 3), 1'b0);
        t = 0;
        while (m_start_o == '0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("t5_issue_seen", 64'(m_start_o), 64'hF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rst_op_ready", 64'(op_ready), 64'd0);
        check("t5_rst_pulses", 64'({m_start_o, add_o, final_add_o, acc_clr_o}), 64'd0);
        check("t5_rst_mul", 64'({mul_a_o, mul_b_o}), 64'd0);
        check("t5_rst_res_valid", 64'(res_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5_post_rst_pulses", 64'({m_start_o, add_o, final_add_o, acc_clr_o}), 64'd0);
        max_skew = 0;
        va[0] = 16'd2; va[1] = 16'd2;
        vb[0] = 16'd3; vb[1] = 16'd3;
        run_job(2, 0, 0);
        check("t5_literal", 64'(res_data), 64'd12);

        // Input gaps and skewed lane completion.
        max_skew = 6;
        max_fin  = 4;
        for (int i = 0; i < 4; i++) begin
            va[i] = 16'(i + 1);
            vb[i] = 16'(i + 5);
        end
        run_job(4, 3, 0);
        check("t6_literal", 64'(res_data), 64'd70);

        // Random jobs.
        for (int j = 0; j < 10; j++) begin
            int n = int'($urandom_range(12, 1));
            for (int i = 0; i < n; i++) begin
                va[i] = 16'($urandom);
                vb[i] = 16'($urandom);
            end
            run_job(n, int'($urandom_range(2, 0)), int'($urandom_range(4, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
